// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - drain FSM state encoding and default widths shared with the upstream FIFO
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int BUF_WIDTH_DEF  = 4;
    localparam int SKID_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } drain_state_e;

    function automatic drain_state_e state_of(input logic [1:0] occ, input logic infl);
        if (occ == 2'd2) begin
            return FULL;
        end else if (occ != 2'd0 || infl) begin
            return RUN;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// rtl/fifo_drain_skid.sv - two-entry output buffer; head register feeds the downstream port directly
module fifo_drain_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_occ;

    // The rd_en throttle upstream guarantees a push never arrives while full without a pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (i_push) begin
                        r_head <= i_push_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push, i_pop})
                        2'b11: r_head <= i_push_data;
                        2'b10: begin
                            r_tail <= i_push_data;
                            r_occ  <= 2'd2;
                        end
                        2'b01: r_occ <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_push_data;
                        end else begin
                            r_occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains an upstream FIFO into a valid/ready stream; FIFO_DRAIN_STATS_EN adds pop_count
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_WIDTH  = BUF_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_out,
    output logic                  rd_en,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [BUF_WIDTH:0]    pop_count
`endif
);

    typedef logic [BUF_WIDTH:0] pop_count_t;

    logic         r_infl;
    drain_state_e r_state;
    logic [1:0]   w_occ;
    logic         w_xfer;
    logic [2:0]   w_pending;

    fifo_drain_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_push      (r_infl),
        .i_push_data (buf_out),
        .i_pop       (w_xfer),
        .o_head      (out_data),
        .o_occ       (w_occ)
    );

    assign out_valid = (w_occ != 2'd0);
    assign w_xfer    = out_valid && out_ready;

    // Words committed after this edge: buffered plus in flight, minus the one leaving now.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_xfer};
    assign rd_en     = rst && enable && !buf_empty && (w_pending < 3'(SKID_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_infl  <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_infl  <= rd_en;
            r_state <= state_of(w_pending[1:0], rd_en);
        end
    end

    assign busy = (r_state != IDLE);

`ifdef FIFO_DRAIN_STATS_EN
    pop_count_t r_pop_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pop_count <= '0;
        end else if (w_xfer) begin
            r_pop_count <= r_pop_count + pop_count_t'(1);
        end
    end

    assign pop_count = r_pop_count;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - scoreboard bench for fifo_drain; FIFO_DRAIN_STATS_EN adds the pop_count wrap test
module tb_fifo_drain;

    localparam int DW    = 4;
    localparam int BW    = 4;
    localparam int MEM_N = 4096;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          enable    = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] buf_out   = '0;
    logic          buf_empty;
    logic          rd_en;
    logic          out_valid;
    logic          busy;
    logic [DW-1:0] out_data;
`ifdef FIFO_DRAIN_STATS_EN
    logic [BW:0]   pop_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fifo_drain #(
        .DATA_WIDTH (DW),
        .BUF_WIDTH  (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .buf_empty (buf_empty),
        .buf_out   (buf_out),
        .rd_en     (rd_en),
        .enable    (enable),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .pop_count (pop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO: stimulus owns wr_ptr, this model owns rd_ptr; data valid the cycle after a pop.
    logic [DW-1:0] mem [MEM_N];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign buf_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd_en && !buf_empty) begin
            buf_out <= mem[rd_ptr % MEM_N];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    logic [DW-1:0] exp_q [$];

    task automatic load(input logic [DW-1:0] w);
        mem[wr_ptr % MEM_N] = w;
        exp_q.push_back(w);
        wr_ptr = wr_ptr + 1;
    endtask

    // Monitor: words popped upstream but not yet delivered are "held" by the DUT.
    int            delivered  = 0;
    int            prev_rd    = 0;
    int            held;
    logic          pend_xfer  = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (pend_xfer) delivered++;
        pend_xfer = 1'b0;
        if (!rst) begin
            while (delivered < rd_ptr) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                delivered++;
            end
            prev_rd    = rd_ptr;
            prev_stall = 1'b0;
            check("reset_out_valid", int'(out_valid), 0);
            check("reset_out_data", int'(out_data), 0);
            check("reset_rd_en", int'(rd_en), 0);
            check("reset_busy", int'(busy), 0);
        end else begin
            held = rd_ptr - delivered;
            check("held_le_2", int'(held <= 2), 1);
            check("busy_vs_held", int'(busy), int'(held != 0));
            check("valid_latency", int'(out_valid), int'((prev_rd - delivered) > 0));
            check("no_underflow", int'(rd_en && buf_empty), 0);
            if (prev_stall) check("stall_hold", int'({out_valid, out_data}), int'({1'b1, prev_data}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", 1, 0);
                else check("data_order", int'(out_data), int'(exp_q.pop_front()));
                pend_xfer = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_rd    = rd_ptr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        enable    = 1'b1;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && k < 5000) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    logic          rd_log [8];
    logic          v_log  [8];
    logic [DW-1:0] d_log  [8];
    int            n_rd;
    logic          seen;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Empty upstream FIFO
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("empty_rd_en", int'(rd_en), 0);
            check("empty_busy", int'(busy), 0);
            check("empty_valid", int'(out_valid), 0);
            tick();
        end

        // Streaming: four preloaded words
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) load(DW'(i));
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_log[i] = rd_en;
            v_log[i]  = out_valid;
            d_log[i]  = out_data;
        end
        for (int i = 0; i < 8; i++) begin
            check("stream_rd_en", int'(rd_log[i]), int'(i < 4));
            check("stream_valid", int'(v_log[i]), int'(i >= 2 && i < 6));
            if (i >= 2 && i < 6) check("stream_data", int'(d_log[i]), i - 1);
        end
        tick();

        // Backpressure: five words, downstream stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) load(DW'(i));
        n_rd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_rd += int'(rd_en);
        end
        check("bp_rd_pulses", n_rd, 2);
        check("bp_occ", int'(dut.u_skid.r_occ), 2);
        check("bp_state_full", int'(dut.r_state), 2);
        check("bp_head_data", int'(out_data), 1);
        check("bp_valid", int'(out_valid), 1);
        tick();
        drain("bp_drain");

        // Enable dropped right after the first rd_en
        tick();
        out_ready = 1'b1;
        for (int i = 7; i <= 9; i++) load(DW'(i));
        @(negedge clk);
        check("gate_first_rd_en", int'(rd_en), 1);
        tick();
        enable = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("gate_no_rd_en", int'(rd_en), 0);
            if (out_valid && out_data == DW'(7)) seen = 1'b1;
        end
        check("gate_inflight_word", int'(seen), 1);
        check("gate_busy_after", int'(busy), 0);
        tick();
        drain("gate_drain");

        // Asynchronous reset with the buffer full
        tick();
        out_ready = 1'b0;
        for (int i = 3; i <= 6; i++) load(DW'(i));
        repeat (4) tick();
        check("arst_pre_busy", int'(busy), 1);
        check("arst_pre_valid", int'(out_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid_now", int'(out_valid), 0);
        check("arst_busy_now", int'(busy), 0);
        check("arst_rd_en_now", int'(rd_en), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("arst_release_rd_en", int'(rd_en), 1);
        tick();
        drain("arst_drain");

        // Randomized traffic with occasional mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) load(DW'($urandom));
            end
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
            end else begin
                tick();
            end
        end
        drain("random_drain");

`ifdef FIFO_DRAIN_STATS_EN
        do_reset();
        check("stats_reset", int'(pop_count), 0);
        for (int i = 0; i < 33; i++) load(DW'(i));
        drain("stats_drain");
        @(negedge clk);
        check("stats_wrap", int'(pop_count), 1);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
